apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master_if.sv | 39 +++
 rtl/apb_master.sv | 125 ++++++++++++
 tb/tb_apb_master.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_if.sv
// Bundles the local command/response handshake and the APB bus signals of apb_master.
// The master modport is the requester's view; the slave modport serves the local client and the APB slave.
interface apb_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic              PSELx;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic              PREADY;
    logic [DATA_W-1:0] PRDATA;
    logic              PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  PREADY, PRDATA, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output PSELx, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output PREADY, PRDATA, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  PSELx, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB requester: turns local commands into SETUP/ACCESS transfers,
// returns a one-cycle response pulse, and aborts transfers that wait longer than TIMEOUT.
module apb_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic         PCLK,
    input  logic         PRESETn,
    apb_master_if.master bus
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic [CNT_W-1:0]  w_wait_cnt_nxt;
    logic              w_accept;
    logic              w_done;
    logic              w_abort;
    logic              w_cmd_ready;

    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic [DATA_W-1:0] r_rsp_rdata;

    // Saturating increment keeps a long wait from wrapping back under the limit when TIMEOUT=0.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_accept       = 1'b0;
        w_done         = 1'b0;
        w_abort        = 1'b0;
        w_cmd_ready    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    w_accept       = 1'b1;
                    w_state_nxt    = ST_SETUP;
                    w_wait_cnt_nxt = '0;
                end
            end
            ST_SETUP: begin
                w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (bus.PREADY) begin
                    w_cmd_ready = 1'b1;
                    w_done      = 1'b1;
                    if (bus.cmd_valid) begin
                        w_accept       = 1'b1;
                        w_state_nxt    = ST_SETUP;
                        w_wait_cnt_nxt = '0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if ((TIMEOUT > 0) && (r_wait_cnt == CNT_LAST)) begin
                    // cmd_ready is already low here, so the abort edge never takes a new command.
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_wait_cnt_nxt = sat_inc(r_wait_cnt);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_pwrite <= bus.cmd_write;
                r_paddr  <= bus.cmd_addr;
                r_pwdata <= bus.cmd_wdata;
            end
            r_rsp_valid <= w_done | w_abort;
            r_rsp_err   <= w_done ? bus.PSLVERR : w_abort;
            r_rsp_rdata <= (w_done && !r_pwrite) ? bus.PRDATA : '0;
        end
    end

    assign bus.cmd_ready = w_cmd_ready;
    assign bus.PSELx     = (r_state != ST_IDLE);
    assign bus.PENABLE   = (r_state == ST_ACCESS);
    assign bus.PWRITE    = r_pwrite;
    assign bus.PADDR     = r_paddr;
    assign bus.PWDATA    = r_pwdata;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_rdata = r_rsp_rdata;
endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: drives commands and an APB slave model, and scores every response
// against expectations queued when each command is issued.
module tb_apb_master;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic PCLK    = 1'b0;
    logic PRESETn = 1'b0;

    always #5 PCLK = ~PCLK;

    apb_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    apb_master #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) u_dut (
        .PCLK   (PCLK),
        .PRESETn(PRESETn),
        .bus    (bus.master)
    );

    typedef struct {
        logic [DATA_W-1:0] rdata;
        logic              err;
    } rsp_t;

    rsp_t sb_q[$];
    int   n_vec = 0;
    int   n_mis = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_mis++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic push_exp(input logic [DATA_W-1:0] rdata, input logic err);
        rsp_t e;
        e.rdata = rdata;
        e.err   = err;
        sb_q.push_back(e);
    endtask

    // Response scoreboard: every rsp_valid cycle must match the oldest queued expectation.
    always @(negedge PCLK) begin
        if (bus.rsp_valid === 1'b1) begin
            rsp_t e;
            if (sb_q.size() == 0) begin
                chk("rsp_unexpected", 64'(bus.rsp_valid), 64'(0));
            end else begin
                e = sb_q.pop_front();
                chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
                chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
            end
        end
    end

    task automatic junk_slave();
        bus.PREADY  = 1'($urandom);
        bus.PRDATA  = DATA_W'($urandom);
        bus.PSLVERR = 1'($urandom);
    endtask

    // One transfer from IDLE with 'waits' PREADY-low ACCESS cycles; ends in the response cycle.
    task automatic xfer(input logic wr, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] rdata,
                        input logic err, input int waits);
        push_exp(wr ? '0 : rdata, err);
        chk("rdy_idle", 64'(bus.cmd_ready), 64'(1));
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        junk_slave();
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_write = ~wr;
        bus.cmd_addr  = ADDR_W'($urandom);
        bus.cmd_wdata = DATA_W'($urandom);
        chk("setup_sel", 64'(bus.PSELx), 64'(1));
        chk("setup_en", 64'(bus.PENABLE), 64'(0));
        chk("setup_addr", 64'(bus.PADDR), 64'(addr));
        chk("setup_wr", 64'(bus.PWRITE), 64'(wr));
        if (wr) chk("setup_wdata", 64'(bus.PWDATA), 64'(wdata));
        bus.PREADY  = 1'b0;
        bus.PRDATA  = rdata;
        bus.PSLVERR = err;
        tick();
        for (int w = 0; w < waits; w++) begin
            chk("wait_en", 64'(bus.PENABLE), 64'(1));
            chk("wait_addr", 64'(bus.PADDR), 64'(addr));
            chk("wait_rdy", 64'(bus.cmd_ready), 64'(0));
            tick();
        end
        bus.PREADY = 1'b1;
        chk("acc_en", 64'(bus.PENABLE), 64'(1));
        chk("acc_addr", 64'(bus.PADDR), 64'(addr));
        tick();
        chk("rsp_vld", 64'(bus.rsp_valid), 64'(1));
        chk("rsp_idle", 64'(bus.PSELx), 64'(0));
        junk_slave();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.PREADY    = 1'b1;
        bus.PRDATA    = '0;
        bus.PSLVERR   = 1'b0;

        // Reset state
        #12;
        chk("rst_sel", 64'(bus.PSELx), 64'(0));
        chk("rst_en", 64'(bus.PENABLE), 64'(0));
        chk("rst_addr", 64'(bus.PADDR), 64'(0));
        chk("rst_wdata", 64'(bus.PWDATA), 64'(0));
        chk("rst_rsp", 64'(bus.rsp_valid), 64'(0));
        chk("rst_rdy", 64'(bus.cmd_ready), 64'(1));
        #10;
        PRESETn = 1'b1;
        tick();

        // Zero-wait write, then a read with three wait states
        xfer(1'b1, 32'd2, 32'd999, 32'hDEAD_0000, 1'b0, 0);
        tick();
        chk("pulse_one", 64'(bus.rsp_valid), 64'(0));
        chk("idle_hold_addr", 64'(bus.PADDR), 64'(2));
        xfer(1'b0, 32'd7, 32'd0, 32'h1234, 1'b0, 3);

        // Back-to-back write then read with cmd_valid held
        bus.PREADY    = 1'b1;
        bus.PSLVERR   = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 32'd3;
        bus.cmd_wdata = 32'd555;
        push_exp('0, 1'b0);
        tick();
        chk("b2b_sel0", 64'(bus.PSELx), 64'(1));
        chk("b2b_en0", 64'(bus.PENABLE), 64'(0));
        chk("b2b_addr0", 64'(bus.PADDR), 64'(3));
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'd6;
        bus.PRDATA    = 32'hA5A5;
        push_exp(32'hA5A5, 1'b0);
        tick();
        chk("b2b_sel1", 64'(bus.PSELx), 64'(1));
        chk("b2b_en1", 64'(bus.PENABLE), 64'(1));
        chk("b2b_rdy1", 64'(bus.cmd_ready), 64'(1));
        tick();
        bus.cmd_valid = 1'b0;
        chk("b2b_sel2", 64'(bus.PSELx), 64'(1));
        chk("b2b_en2", 64'(bus.PENABLE), 64'(0));
        chk("b2b_addr2", 64'(bus.PADDR), 64'(6));
        chk("b2b_wr2", 64'(bus.PWRITE), 64'(0));
        chk("b2b_rsp1", 64'(bus.rsp_valid), 64'(1));
        tick();
        chk("b2b_sel3", 64'(bus.PSELx), 64'(1));
        chk("b2b_en3", 64'(bus.PENABLE), 64'(1));
        tick();
        chk("b2b_rsp2", 64'(bus.rsp_valid), 64'(1));
        chk("b2b_idle", 64'(bus.PSELx), 64'(0));

        // Timeout with a command held pending during the stalled access
        push_exp('0, 1'b1);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'd9;
        tick();
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 32'd11;
        bus.PREADY    = 1'b0;
        bus.PSLVERR   = 1'b0;
        bus.PRDATA    = 32'hFFFF_FFFF;
        tick();
        cnt = 0;
        while (bus.PENABLE === 1'b1 && cnt < 40) begin
            cnt++;
            tick();
        end
        chk("to_cycles", 64'(cnt), 64'(TIMEOUT));
        chk("to_no_accept", 64'(bus.PSELx), 64'(0));
        chk("to_rsp", 64'(bus.rsp_valid), 64'(1));
        bus.cmd_valid = 1'b0;
        bus.PREADY    = 1'b1;
        tick();

        // Slave error on a write, then a clean read
        xfer(1'b1, 32'd4, 32'd1, 32'h0, 1'b1, 0);
        xfer(1'b0, 32'd5, 32'd0, 32'h55, 1'b0, 1);

        // Reset during ACCESS aborts silently
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 32'd8;
        bus.cmd_wdata = 32'hCAFE;
        bus.PREADY    = 1'b0;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        tick();
        chk("pre_rst_en", 64'(bus.PENABLE), 64'(1));
        #2;
        PRESETn = 1'b0;
        #1;
        chk("mid_rst_sel", 64'(bus.PSELx), 64'(0));
        chk("mid_rst_en", 64'(bus.PENABLE), 64'(0));
        chk("mid_rst_addr", 64'(bus.PADDR), 64'(0));
        chk("mid_rst_wdata", 64'(bus.PWDATA), 64'(0));
        chk("mid_rst_wr", 64'(bus.PWRITE), 64'(0));
        tick();
        tick();
        PRESETn    = 1'b1;
        bus.PREADY = 1'b1;
        tick();
        xfer(1'b0, 32'd6, 32'd0, 32'h6666, 1'b0, 0);

        // Random mix of transfers and wait states
        for (int i = 0; i < 8; i++) begin
            xfer(1'($urandom), ADDR_W'($urandom), DATA_W'($urandom), DATA_W'($urandom),
                 1'($urandom), int'($urandom_range(0, 4)));
        end

        tick();
        tick();
        chk("sb_empty", 64'(sb_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
